// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter slice: opcode width and encodings
// seen on the ALU opcode bus, and the arbiter FSM state type.
package salamander_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_ADD = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB = 4'd1;
  localparam logic [OP_W-1:0] OP_INC = 4'd2;
  localparam logic [OP_W-1:0] OP_DEC = 4'd3;
  localparam logic [OP_W-1:0] OP_AND = 4'd4;
  localparam logic [OP_W-1:0] OP_OR  = 4'd5;
  localparam logic [OP_W-1:0] OP_XOR = 4'd6;
  localparam logic [OP_W-1:0] OP_SHL = 4'd7;
  localparam logic [OP_W-1:0] OP_SHR = 4'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester-side bundle of the ALU arbiter.
//   req_valid/req_ready  per-requester request handshake
//   req_op/left/right/carry  per-requester payload, index i = requester i
//   rsp_valid/rsp_ready  per-requester response handshake
//   rsp_data/rsp_carry   shared result bus
// master = requester side, slave = arbiter side.
interface alu_arbiter_if
  import salamander_pkg::*;
#(
  parameter int SIZE    = 8,
  parameter int NUM_REQ = 2
);

  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ-1:0][OP_W-1:0] req_op;
  logic [NUM_REQ-1:0][SIZE-1:0] req_left;
  logic [NUM_REQ-1:0][SIZE-1:0] req_right;
  logic [NUM_REQ-1:0]           req_carry;
  logic [NUM_REQ-1:0]           rsp_valid;
  logic [NUM_REQ-1:0]           rsp_ready;
  logic [SIZE-1:0]              rsp_data;
  logic                         rsp_carry;

  modport master (
    output req_valid, req_op, req_left, req_right, req_carry, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_carry
  );

  modport slave (
    input  req_valid, req_op, req_left, req_right, req_carry, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_carry
  );

endinterface

// File: rtl/alu_arbiter_picker.sv
// rr_picker: stateless round-robin selection.
//   req_valid   in   pending requests
//   last_grant  in   index granted last
//   grant_oh    out  one-hot winner (zero if none valid)
//   grant_idx   out  winner index
//   grant_any   out  at least one request valid
// Search order is last_grant+1, last_grant+2, ... wrapping modulo NUM_REQ.
module rr_picker #(
  parameter  int NUM_REQ = 2,
  localparam int GW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [GW-1:0]      last_grant,
  output logic [NUM_REQ-1:0] grant_oh,
  output logic [GW-1:0]      grant_idx,
  output logic               grant_any
);

  logic [GW-1:0] cand;

  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    cand      = '0;
    // Walk from the farthest candidate back to the nearest; the last hit
    // overwrites earlier ones, so the nearest valid after last_grant wins.
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = GW'((int'(last_grant) + k) % NUM_REQ);
      if (req_valid[cand]) begin
        grant_oh       = '0;
        grant_oh[cand] = 1'b1;
        grant_idx      = cand;
      end
    end
  end

  assign grant_any = |req_valid;

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between NUM_REQ requesters.
//   clk, rstn        clock / async active-low reset
//   bus (slave)      request + response handshakes (see alu_arbiter_if)
//   grant_id         requester owning the current transaction
//   busy             high in EXEC and RESP
//   alu_ce           ALU enable, high only in EXEC
//   alu_op_code/left/right/carry_in  registered ALU inputs
//   alu_op_out/carry_out             ALU result, captured at end of EXEC
// Flow: IDLE (arbitrate, capture payload) -> EXEC (ALU enabled, capture
// result) -> RESP (hold result until the owner takes it) -> IDLE.
module alu_arbiter
  import salamander_pkg::*;
#(
  parameter  int SIZE    = 8,
  parameter  int NUM_REQ = 2,
  localparam int GW      = $clog2(NUM_REQ)
) (
  input  logic             clk,
  input  logic             rstn,
  alu_arbiter_if.slave     bus,
  output logic [GW-1:0]    grant_id,
  output logic             busy,
  output logic             alu_ce,
  output logic [OP_W-1:0]  alu_op_code,
  output logic [SIZE-1:0]  alu_left,
  output logic [SIZE-1:0]  alu_right,
  output logic             alu_carry_in,
  input  logic [SIZE-1:0]  alu_op_out,
  input  logic             alu_carry_out
);

  arb_state_t         state, state_nxt;
  logic [GW-1:0]      last_grant;
  logic [NUM_REQ-1:0] pick_oh;
  logic [GW-1:0]      pick_idx;
  logic               pick_any;
  logic               accept, rsp_take;
  logic [SIZE-1:0]    rsp_data_q;
  logic               rsp_carry_q;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_valid  (bus.req_valid),
    .last_grant (last_grant),
    .grant_oh   (pick_oh),
    .grant_idx  (pick_idx),
    .grant_any  (pick_any)
  );

  always_comb begin
    state_nxt     = state;
    accept        = 1'b0;
    rsp_take      = 1'b0;
    busy          = 1'b0;
    alu_ce        = 1'b0;
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    unique case (state)
      IDLE: if (pick_any) begin
        accept    = 1'b1;
        state_nxt = EXEC;
        // Gated so a requester never sees an accept while reset is held.
        if (rstn) bus.req_ready = pick_oh;
      end
      EXEC: begin
        busy      = 1'b1;
        alu_ce    = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        busy                    = 1'b1;
        bus.rsp_valid[grant_id] = 1'b1;
        // Only the owner's rsp_ready matters; others are ignored.
        if (bus.rsp_ready[grant_id]) begin
          rsp_take  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      last_grant   <= GW'(NUM_REQ - 1);
      grant_id     <= '0;
      alu_op_code  <= '0;
      alu_left     <= '0;
      alu_right    <= '0;
      alu_carry_in <= 1'b0;
      rsp_data_q   <= '0;
      rsp_carry_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      // Operands are only loaded on accept, so the ALU inputs stay quiet
      // between transactions.
      if (accept) begin
        grant_id     <= pick_idx;
        alu_op_code  <= bus.req_op[pick_idx];
        alu_left     <= bus.req_left[pick_idx];
        alu_right    <= bus.req_right[pick_idx];
        alu_carry_in <= bus.req_carry[pick_idx];
      end
      if (state == EXEC) begin
        rsp_data_q  <= alu_op_out;
        rsp_carry_q <= alu_carry_out;
      end
      if (rsp_take) last_grant <= grant_id;
    end
  end

  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_carry = rsp_carry_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: per-requester request queues drive the bus, a
// priority-rotation model predicts each accept and pushes the expected
// response onto a scoreboard; a separate monitor checks timing and data.
module tb_alu_arbiter;
  import salamander_pkg::*;

  localparam int SIZE    = 8;
  localparam int NUM_REQ = 2;
  localparam int GW      = $clog2(NUM_REQ);

  typedef struct {
    logic [OP_W-1:0] op;
    logic [SIZE-1:0] l;
    logic [SIZE-1:0] r;
    logic            c;
    logic [SIZE-1:0] d;
    logic            co;
  } req_t;

  typedef struct {
    logic [GW-1:0] id;
    int            acc;
    req_t          rq;
  } exp_t;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  alu_arbiter_if #(.SIZE(SIZE), .NUM_REQ(NUM_REQ)) bus ();

  logic [GW-1:0]   grant_id;
  logic            busy, alu_ce, alu_carry_in, alu_carry_out;
  logic [OP_W-1:0] alu_op_code;
  logic [SIZE-1:0] alu_left, alu_right, alu_op_out;

  alu_arbiter #(.SIZE(SIZE), .NUM_REQ(NUM_REQ)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .bus           (bus.slave),
    .grant_id      (grant_id),
    .busy          (busy),
    .alu_ce        (alu_ce),
    .alu_op_code   (alu_op_code),
    .alu_left      (alu_left),
    .alu_right     (alu_right),
    .alu_carry_in  (alu_carry_in),
    .alu_op_out    (alu_op_out),
    .alu_carry_out (alu_carry_out)
  );

  // ALU behaviour: {carry, result}
  function automatic logic [SIZE:0] alu_model(input logic [OP_W-1:0] op,
      input logic [SIZE-1:0] l, input logic [SIZE-1:0] r, input logic c);
    logic [SIZE:0] el, er, ec;
    el = {1'b0, l};
    er = {1'b0, r};
    ec = {{SIZE{1'b0}}, c};
    case (op)
      OP_ADD:  return el + er + ec;
      OP_SUB:  return el - er - ec;
      OP_INC:  return el + (SIZE+1)'(1);
      OP_DEC:  return el - (SIZE+1)'(1);
      OP_AND:  return {1'b0, l & r};
      OP_OR:   return {1'b0, l | r};
      OP_XOR:  return {1'b0, l ^ r};
      OP_SHL:  return {l, 1'b0};
      OP_SHR:  return {l[0], 1'b0, l[SIZE-1:1]};
      default: return el;
    endcase
  endfunction

  // Disabled ALU output is scrambled so a capture outside EXEC shows up.
  logic [SIZE:0] alu_res;
  always_comb begin
    alu_res = alu_model(alu_op_code, alu_left, alu_right, alu_carry_in);
    if (!alu_ce) alu_res = ~alu_res;
  end
  assign alu_op_out    = alu_res[SIZE-1:0];
  assign alu_carry_out = alu_res[SIZE];

  int   cyc = 0, n_chk = 0, n_pass = 0;
  bit   mon_en = 1'b0, gaps = 1'b0, drops = 1'b0;
  int   rdy_mode = 0;  // 0 all ready, 1 random, 2 requester 0 stalls, others ready
  exp_t sb_q[$];
  req_t pend[NUM_REQ][$];
  logic [GW-1:0] prio[$];  // search order: front = highest priority
  int   grant_log[$];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
  endfunction

  function automatic req_t mk(input logic [OP_W-1:0] op, input logic [SIZE-1:0] l,
      input logic [SIZE-1:0] r, input logic c, input logic [SIZE-1:0] d, input logic co);
    req_t q;
    q.op = op; q.l = l; q.r = r; q.c = c; q.d = d; q.co = co;
    return q;
  endfunction

  function automatic req_t mk_rand();
    req_t q;
    logic [SIZE:0] res;
    q.op = OP_W'($urandom_range(0, (1 << OP_W) - 1));
    q.l  = SIZE'($urandom);
    q.r  = SIZE'($urandom);
    q.c  = 1'($urandom);
    res  = alu_model(q.op, q.l, q.r, q.c);
    q.d  = res[SIZE-1:0];
    q.co = res[SIZE];
    return q;
  endfunction

  task automatic drive(input logic [NUM_REQ-1:0] acc);
    for (int i = 0; i < NUM_REQ; i++) begin
      logic [GW-1:0] ix;
      ix = GW'(i);
      if (acc[ix]) begin
        void'(pend[i].pop_front());
        bus.req_valid[ix] = 1'b0;
      end else if (bus.req_valid[ix] && drops && $urandom_range(0, 7) == 0) begin
        bus.req_valid[ix] = 1'b0;
      end
      if (!bus.req_valid[ix]) begin
        bus.req_op[ix]    = OP_W'($urandom);
        bus.req_left[ix]  = SIZE'($urandom);
        bus.req_right[ix] = SIZE'($urandom);
        bus.req_carry[ix] = 1'($urandom);
        if (pend[i].size() > 0 && (!gaps || $urandom_range(0, 2) != 0)) begin
          bus.req_valid[ix] = 1'b1;
          bus.req_op[ix]    = pend[i][0].op;
          bus.req_left[ix]  = pend[i][0].l;
          bus.req_right[ix] = pend[i][0].r;
          bus.req_carry[ix] = pend[i][0].c;
        end
      end
      case (rdy_mode)
        0:       bus.rsp_ready[ix] = 1'b1;
        1:       bus.rsp_ready[ix] = 1'($urandom);
        default: bus.rsp_ready[ix] = (i != 0);
      endcase
    end
  endtask

  // One cycle: predict and check the accept, record it, then drive.
  task automatic step();
    logic [NUM_REQ-1:0] exp_rdy;
    logic [GW-1:0]      w;
    bit                 found;
    exp_t               e;
    @(negedge clk);
    cyc++;
    exp_rdy = '0;
    found   = 1'b0;
    w       = '0;
    if (sb_q.size() == 0)
      foreach (prio[k])
        if (!found && bus.req_valid[prio[k]]) begin
          found = 1'b1;
          w     = prio[k];
        end
    if (found) exp_rdy[w] = 1'b1;
    chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    if (found) begin
      e.id  = w;
      e.acc = cyc;
      e.rq  = pend[int'(w)][0];
      sb_q.push_back(e);
      grant_log.push_back(int'(w));
    end
    @(posedge clk);
    #1;
    drive(exp_rdy);
  endtask

  task automatic drain();
    int guard, left;
    guard = 0;
    left  = 1;
    while (left > 0 && guard < 3000) begin
      step();
      guard++;
      left = sb_q.size();
      for (int i = 0; i < NUM_REQ; i++) left += pend[i].size();
    end
    chk("drain_outstanding", 32'(left), 32'd0);
  endtask

  task automatic do_reset(input int n);
    rstn = 1'b0;
    sb_q.delete();
    prio.delete();
    for (int i = 0; i < NUM_REQ; i++) prio.push_back(GW'(i));
    drive('0);
    repeat (n) begin
      @(negedge clk);
      chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_rsp_data",  32'(bus.rsp_data),  32'd0);
      chk("rst_rsp_carry", 32'(bus.rsp_carry), 32'd0);
      chk("rst_grant_id",  32'(grant_id),      32'd0);
      chk("rst_busy",      32'(busy),          32'd0);
      chk("rst_alu_ce",    32'(alu_ce),        32'd0);
      chk("rst_alu_op",    32'(alu_op_code),   32'd0);
      chk("rst_alu_left",  32'(alu_left),      32'd0);
      chk("rst_alu_right", 32'(alu_right),     32'd0);
      chk("rst_alu_cin",   32'(alu_carry_in),  32'd0);
    end
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  // Response monitor: runs just after the stimulus checker each cycle.
  initial begin
    forever begin
      logic [NUM_REQ-1:0] ev;
      bit   ce, bz;
      exp_t e;
      @(negedge clk);
      #1;
      if (mon_en && rstn) begin
        ev = '0; ce = 1'b0; bz = 1'b0;
        e  = '{default: '0};
        if (sb_q.size() > 0) begin
          e  = sb_q[0];
          ce = (cyc == e.acc + 1);
          bz = (cyc >= e.acc + 1);
          if (cyc >= e.acc + 2) ev[e.id] = 1'b1;
        end
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(ev));
        chk("alu_ce",    32'(alu_ce),        32'(ce));
        chk("busy",      32'(busy),          32'(bz));
        if (bz) begin
          chk("alu_op_code",  32'(alu_op_code),  32'(e.rq.op));
          chk("alu_left",     32'(alu_left),     32'(e.rq.l));
          chk("alu_right",    32'(alu_right),    32'(e.rq.r));
          chk("alu_carry_in", 32'(alu_carry_in), 32'(e.rq.c));
        end
        if (ev != '0) begin
          chk("grant_id",  32'(grant_id),      32'(e.id));
          chk("rsp_data",  32'(bus.rsp_data),  32'(e.rq.d));
          chk("rsp_carry", 32'(bus.rsp_carry), 32'(e.rq.co));
          if (bus.rsp_ready[e.id]) begin
            void'(sb_q.pop_front());
            while (prio[$] != e.id) prio.push_back(prio.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    rstn          = 1'b1;
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_left  = '0;
    bus.req_right = '0;
    bus.req_carry = '0;
    bus.rsp_ready = '0;
    @(posedge clk);
    #1;
    do_reset(2);
    mon_en = 1'b1;

    // single requester, basic add and its latency
    pend[0].push_back(mk(OP_ADD, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0));
    drain();

    // overflow and subtract on requester 1
    pend[1].push_back(mk(OP_ADD, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1));
    pend[1].push_back(mk(OP_SUB, 8'h02, 8'h01, 1'b0, 8'h01, 1'b0));
    drain();

    // per-operation results
    pend[0].push_back(mk(OP_AND, 8'hFF, 8'h55, 1'b0, 8'h55, 1'b0));
    pend[0].push_back(mk(OP_OR,  8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0));
    pend[0].push_back(mk(OP_XOR, 8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0));
    pend[0].push_back(mk(OP_SHL, 8'h10, 8'h00, 1'b0, 8'h20, 1'b0));
    pend[0].push_back(mk(OP_SHR, 8'h10, 8'h00, 1'b0, 8'h08, 1'b0));
    pend[0].push_back(mk(OP_DEC, 8'h80, 8'h00, 1'b0, 8'h7F, 1'b0));
    drain();

    // both requesters continuously valid after reset: strict alternation
    do_reset(1);
    grant_log.delete();
    for (int k = 0; k < 4; k++) begin
      pend[0].push_back(mk_rand());
      pend[1].push_back(mk_rand());
    end
    drain();
    chk("alt_count", 32'(grant_log.size()), 32'd8);
    for (int k = 0; k < grant_log.size(); k++)
      chk($sformatf("alt_grant_%0d", k), 32'(grant_log[k]), 32'(k % 2));

    // backpressure: owner stalls, the other requester's rsp_ready is high
    rdy_mode = 2;
    pend[0].push_back(mk(OP_ADD, 8'h3C, 8'h0F, 1'b1, 8'h4C, 1'b0));
    pend[1].push_back(mk(OP_XOR, 8'hF0, 8'h0F, 1'b0, 8'hFF, 1'b0));
    repeat (9) step();
    chk("bp_still_pending", 32'(bus.rsp_valid), 32'd1);
    rdy_mode = 0;
    drain();

    // reset while the transaction is in EXEC
    grant_log.delete();
    pend[0].push_back(mk(OP_INC, 8'h41, 8'h00, 1'b0, 8'h42, 1'b0));
    pend[1].push_back(mk(OP_SUB, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1));
    for (int k = 0; k < 10 && grant_log.size() == 0; k++) step();
    chk("exec_reached", 32'(grant_log.size()), 32'd1);
    pend[0].push_back(mk(OP_ADD, 8'h20, 8'h22, 1'b1, 8'h43, 1'b0));
    do_reset(1);
    grant_log.delete();
    drain();
    chk("post_reset_first_grant", 32'(grant_log.size() > 0 ? grant_log[0] : -1), 32'd0);

    // randomized traffic with gaps, dropped valids and random backpressure
    gaps = 1'b1; drops = 1'b1; rdy_mode = 1;
    for (int k = 0; k < 300; k++) pend[$urandom_range(0, NUM_REQ - 1)].push_back(mk_rand());
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
